multi_lane_descrambler: RTL and testbench

MULTI_LANE_DESCRAMBLER -- requirements
Module: multi_lane_descrambler

---
 rtl/pcs_descrambler_pkg.sv | 26 ++
 rtl/descrambler_lane.sv | 159 +++++++++++++++
 rtl/multi_lane_descrambler.sv | 60 ++++++
 tb/tb_multi_lane_descrambler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_descrambler_pkg.sv
// Shared definitions for the 64b/66b multi-lane descrambler.
// Holds the coded-block geometry, the descrambler tap positions for the
// 1 + x^39 + x^58 polynomial, the lane lock-state encoding and a helper
// that classifies a 2-bit sync header.
package pcs_descrambler_pkg;

    localparam int LEN_CODED_BLOCK = 66;
    localparam int LEN_SCRAMBLER   = 58;
    localparam int NB_SH           = 2;

    // State bit S[i] holds the scrambled bit received (58 - i) bits ago,
    // so S[19] is the x^39 tap and S[0] is the x^58 tap.
    localparam int TAP_HI = 19;
    localparam int TAP_LO = 0;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

    // 01 and 10 are legal sync headers; 00 and 11 are not.
    function automatic logic sh_is_good(input logic [NB_SH-1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

endpackage

// File: rtl/descrambler_lane.sv
// One independent 64b/66b descrambler lane.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_enable              global clock enable (freezes every register when low)
//   i_valid, i_bypass     block strobe; bypass passes data through unscrambled
//   i_data, i_tag         coded block (header in the top 2 bits) and sideband tag
//   i_clear_err           clears the header-error counter
//   o_data, o_valid,
//   o_tag                 registered descrambled block, strobe and tag (1 cycle)
//   o_lock                lane lock indication
//   o_err_cnt             saturating count of blocks with an illegal header
module descrambler_lane #(
    parameter int                           LEN_CODED_BLOCK = pcs_descrambler_pkg::LEN_CODED_BLOCK,
    parameter int                           LEN_SCRAMBLER   = pcs_descrambler_pkg::LEN_SCRAMBLER,
    parameter logic [LEN_SCRAMBLER-1:0]     SEED            = '0,
    parameter int                           LOCK_BLOCKS     = 4,
    parameter int                           NB_ERR_CNT      = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic                        i_bypass,
    input  logic [LEN_CODED_BLOCK-1:0]  i_data,
    input  logic                        i_tag,
    input  logic                        i_clear_err,
    output logic [LEN_CODED_BLOCK-1:0]  o_data,
    output logic                        o_valid,
    output logic                        o_tag,
    output logic                        o_lock,
    output logic [NB_ERR_CNT-1:0]       o_err_cnt
);
    import pcs_descrambler_pkg::*;

    localparam int LEN_PAYLOAD = LEN_CODED_BLOCK - NB_SH;
    localparam int CNT_W       = $clog2(LOCK_BLOCKS + 1);

    // Bit-serial self-synchronising descrambler unrolled over one payload,
    // MSB first. Returns {descrambled payload, next state}.
    function automatic logic [LEN_PAYLOAD+LEN_SCRAMBLER-1:0] descramble(
        input logic [LEN_PAYLOAD-1:0]   din,
        input logic [LEN_SCRAMBLER-1:0] st
    );
        logic [LEN_PAYLOAD-1:0]   dout;
        logic [LEN_SCRAMBLER-1:0] s;
        s    = st;
        dout = '0;
        for (int i = LEN_PAYLOAD - 1; i >= 0; i--) begin
            dout[i] = din[i] ^ s[TAP_HI] ^ s[TAP_LO];
            s       = {din[i], s[LEN_SCRAMBLER-1:1]};
        end
        return {dout, s};
    endfunction

    logic [LEN_SCRAMBLER-1:0]   state_q, state_d, state_adv;
    logic [LEN_PAYLOAD-1:0]     desc_payload;
    logic [LEN_CODED_BLOCK-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       tag_q, tag_d;
    lock_state_t                lock_q, lock_d;
    logic [CNT_W-1:0]           good_q, good_d;
    logic [NB_ERR_CNT-1:0]      err_q, err_d;

    logic [NB_SH-1:0] sh;
    logic             blk_active;
    logic             blk_good;
    logic             blk_bad;

    assign sh         = i_data[LEN_CODED_BLOCK-1 -: NB_SH];
    // Only enabled, valid, non-bypassed blocks touch the state, lock FSM and counter.
    assign blk_active = i_enable & i_valid & ~i_bypass;
    assign blk_good   = blk_active &  sh_is_good(sh);
    assign blk_bad    = blk_active & ~sh_is_good(sh);

    // Datapath and error counter next state
    always_comb begin
        {desc_payload, state_adv} = descramble(i_data[LEN_PAYLOAD-1:0], state_q);
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        err_d   = err_q;
        if (i_enable) begin
            valid_d = i_valid;
            if (i_valid) begin
                tag_d = i_tag;
                if (i_bypass) begin
                    data_d = i_data;
                end else begin
                    data_d  = {sh, desc_payload};
                    state_d = state_adv;
                end
            end
            // Clear first, then count the current block.
            if (i_clear_err) begin
                err_d = blk_bad ? NB_ERR_CNT'(1) : '0;
            end else if (blk_bad && (err_q != '1)) begin
                err_d = err_q + NB_ERR_CNT'(1);
            end
        end
    end

    // Lock FSM next state
    always_comb begin
        lock_d = lock_q;
        good_d = good_q;
        case (lock_q)
            LOCK_UNLOCKED: begin
                if (blk_bad) begin
                    good_d = '0;
                end else if (blk_good) begin
                    if (good_q == CNT_W'(LOCK_BLOCKS - 1)) begin
                        lock_d = LOCK_LOCKED;
                        good_d = '0;
                    end else begin
                        good_d = good_q + CNT_W'(1);
                    end
                end
            end
            LOCK_LOCKED: begin
                if (blk_bad) begin
                    lock_d = LOCK_UNLOCKED;
                    good_d = '0;
                end
            end
            default: begin
                lock_d = LOCK_UNLOCKED;
                good_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= 1'b0;
            lock_q  <= LOCK_UNLOCKED;
            good_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            lock_q  <= lock_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_tag     = tag_q;
    assign o_lock    = (lock_q == LOCK_LOCKED);
    assign o_err_cnt = err_q;

endmodule

// File: rtl/multi_lane_descrambler.sv
// Multi-lane 64b/66b descrambler: NB_LANES identical, fully independent lanes.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_enable              global clock enable
//   i_valid, i_bypass,
//   i_tag                 per-lane strobe, bypass and sideband tag
//   i_data                lane k at [k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]
//   i_clear_err           clears every lane's header-error counter
//   o_data, o_valid,
//   o_tag, o_lock         per-lane registered outputs, same packing as inputs
//   o_err_cnt             lane k at [k*NB_ERR_CNT +: NB_ERR_CNT]
module multi_lane_descrambler #(
    parameter int                       NB_LANES        = 4,
    parameter int                       LEN_CODED_BLOCK = pcs_descrambler_pkg::LEN_CODED_BLOCK,
    parameter int                       LEN_SCRAMBLER   = pcs_descrambler_pkg::LEN_SCRAMBLER,
    parameter logic [LEN_SCRAMBLER-1:0] SEED            = '0,
    parameter int                       LOCK_BLOCKS     = 4,
    parameter int                       NB_ERR_CNT      = 16
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_enable,
    input  logic [NB_LANES-1:0]                  i_valid,
    input  logic [NB_LANES-1:0]                  i_bypass,
    input  logic [NB_LANES*LEN_CODED_BLOCK-1:0]  i_data,
    input  logic [NB_LANES-1:0]                  i_tag,
    input  logic                                 i_clear_err,
    output logic [NB_LANES*LEN_CODED_BLOCK-1:0]  o_data,
    output logic [NB_LANES-1:0]                  o_valid,
    output logic [NB_LANES-1:0]                  o_tag,
    output logic [NB_LANES-1:0]                  o_lock,
    output logic [NB_LANES*NB_ERR_CNT-1:0]       o_err_cnt
);
    import pcs_descrambler_pkg::*;

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        descrambler_lane #(
            .LEN_CODED_BLOCK (LEN_CODED_BLOCK),
            .LEN_SCRAMBLER   (LEN_SCRAMBLER),
            .SEED            (SEED),
            .LOCK_BLOCKS     (LOCK_BLOCKS),
            .NB_ERR_CNT      (NB_ERR_CNT)
        ) u_lane (
            .i_clock     (i_clock),
            .i_reset     (i_reset),
            .i_enable    (i_enable),
            .i_valid     (i_valid[k]),
            .i_bypass    (i_bypass[k]),
            .i_data      (i_data[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]),
            .i_tag       (i_tag[k]),
            .i_clear_err (i_clear_err),
            .o_data      (o_data[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK]),
            .o_valid     (o_valid[k]),
            .o_tag       (o_tag[k]),
            .o_lock      (o_lock[k]),
            .o_err_cnt   (o_err_cnt[k*NB_ERR_CNT +: NB_ERR_CNT])
        );
    end

endmodule

// File: tb/tb_multi_lane_descrambler.sv
module tb_multi_lane_descrambler;

    localparam int NL  = 4;
    localparam int LCB = 66;
    localparam int EW  = 4;
    localparam int LB  = 4;
    localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

    logic            clk;
    logic            rst;
    logic            en;
    logic [NL-1:0]   valid;
    logic [NL-1:0]   bypass;
    logic [NL-1:0]   tag;
    logic            clr;
    logic [LCB-1:0]  din [NL];
    logic [NL*LCB-1:0] i_data;
    logic [NL*LCB-1:0] o_data;
    logic [NL-1:0]   o_valid;
    logic [NL-1:0]   o_tag;
    logic [NL-1:0]   o_lock;
    logic [NL*EW-1:0] o_err;

    assign i_data = {din[3], din[2], din[1], din[0]};

    multi_lane_descrambler #(
        .NB_LANES    (NL),
        .LOCK_BLOCKS (LB),
        .NB_ERR_CNT  (EW)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_valid     (valid),
        .i_bypass    (bypass),
        .i_data      (i_data),
        .i_tag       (tag),
        .i_clear_err (clr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_tag       (o_tag),
        .o_lock      (o_lock),
        .o_err_cnt   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Scrambler / descrambler history: h[j] is the scrambled bit seen j bits ago.
    logic [58:1]    tx_h [NL];
    logic [58:1]    rx_h [NL];
    logic [LCB-1:0] exp_data [NL];
    logic [NL-1:0]  exp_valid, exp_tag, exp_lock;
    int             run [NL];
    int             exp_err [NL];

    task automatic check(input string name, input logic [LCB-1:0] act, input logic [LCB-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] tx_scramble(input int k, input logic [63:0] p);
        logic [63:0] r;
        for (int b = 63; b >= 0; b--) begin
            r[b]    = p[b] ^ tx_h[k][39] ^ tx_h[k][58];
            tx_h[k] = {tx_h[k][57:1], r[b]};
        end
        return r;
    endfunction

    // Reference behaviour for one enabled/reset clock edge.
    task automatic model_update();
        logic [63:0] s, d;
        logic [1:0]  hdr;
        for (int k = 0; k < NL; k++) begin
            if (rst) begin
                rx_h[k] = '0; exp_data[k] = '0; exp_valid[k] = 1'b0; exp_tag[k] = 1'b0;
                exp_lock[k] = 1'b0; run[k] = 0; exp_err[k] = 0;
            end else if (en) begin
                exp_valid[k] = valid[k];
                if (clr) exp_err[k] = 0;
                if (valid[k]) begin
                    exp_tag[k] = tag[k];
                    if (bypass[k]) begin
                        exp_data[k] = din[k];
                    end else begin
                        s   = din[k][63:0];
                        hdr = din[k][65:64];
                        for (int b = 63; b >= 0; b--) begin
                            d[b]    = s[b] ^ rx_h[k][39] ^ rx_h[k][58];
                            rx_h[k] = {rx_h[k][57:1], s[b]};
                        end
                        exp_data[k] = {hdr, d};
                        if (hdr == 2'b00 || hdr == 2'b11) begin
                            exp_lock[k] = 1'b0;
                            run[k] = 0;
                            if (exp_err[k] < 15) exp_err[k]++;
                        end else if (!exp_lock[k]) begin
                            run[k]++;
                            if (run[k] >= LB) exp_lock[k] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NL; k++) begin
                check($sformatf("data[%0d]", k), o_data[k*LCB +: LCB], exp_data[k]);
                check($sformatf("valid[%0d]", k), LCB'(o_valid[k]), LCB'(exp_valid[k]));
                check($sformatf("tag[%0d]", k), LCB'(o_tag[k]), LCB'(exp_tag[k]));
                check($sformatf("lock[%0d]", k), LCB'(o_lock[k]), LCB'(exp_lock[k]));
                check($sformatf("err[%0d]", k), LCB'(o_err[k*EW +: EW]), LCB'(exp_err[k]));
            end
        end
    end

    task automatic send_good(input logic [63:0] p);
        for (int k = 0; k < NL; k++) din[k] = {2'b01, tx_scramble(k, p)};
    endtask

    initial begin
        logic [63:0] p;
        logic [1:0]  hdr;
        rst = 1'b1; en = 1'b0; valid = '0; bypass = '0; tag = '0; clr = 1'b0;
        for (int k = 0; k < NL; k++) begin
            din[k]  = '0;
            tx_h[k] = '1;   // transmitter starts out of step with the receiver seed
        end
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_lock", LCB'(o_lock), '0);
        check("reset_err", LCB'(o_err), '0);
        check("reset_data0", o_data[LCB-1:0], '0);

        // Idle stream on all lanes
        rst = 1'b0; en = 1'b1; valid = '1;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < NL; k++) din[k] = {2'b10, tx_scramble(k, IDLE)};
            tag = 4'(j);
            tick();
            if (j >= 1)
                for (int k = 0; k < NL; k++)
                    check($sformatf("idle_blk%0d_lane%0d", j, k), o_data[k*LCB +: LCB], {2'b10, IDLE});
            check($sformatf("idle_lock_blk%0d", j), LCB'(o_lock), (j >= 3) ? LCB'(4'hF) : '0);
        end

        // Single bad header on lane 2 while locked
        for (int k = 0; k < NL; k++) din[k] = {(k == 2) ? 2'b11 : 2'b10, tx_scramble(k, IDLE)};
        tick();
        check("bad_hdr_lock", LCB'(o_lock), LCB'(4'b1011));
        check("bad_hdr_err2", LCB'(o_err[2*EW +: EW]), LCB'(1));
        check("bad_hdr_err0", LCB'(o_err[0 +: EW]), '0);
        send_good(IDLE);
        tick();

        // Bypass lane 1 for three blocks, then resume without re-sync
        for (int j = 0; j < 3; j++) begin
            bypass = 4'b0010;
            for (int k = 0; k < NL; k++) begin
                if (k == 1) din[k] = {2'b01, $urandom(), $urandom()};
                else        din[k] = {2'b01, tx_scramble(k, IDLE)};
            end
            tick();
            check($sformatf("bypass_blk%0d", j), o_data[1*LCB +: LCB], din[1]);
        end
        bypass = '0;
        for (int j = 0; j < 2; j++) begin
            p = {$urandom(), $urandom()};
            send_good(p);
            tick();
            check($sformatf("post_bypass_blk%0d", j), o_data[1*LCB +: LCB], {2'b01, p});
        end

        // Randomised traffic with gapped enable
        for (int c = 0; c < 300; c++) begin
            en     = (c % 3) != 2;
            valid  = 4'($urandom());
            tag    = 4'($urandom());
            clr    = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < NL; k++) begin
                bypass[k] = ($urandom_range(0, 7) == 0);
                p   = {$urandom(), $urandom()};
                hdr = ($urandom_range(0, 5) == 0) ? 2'($urandom()) : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
                if (en && valid[k] && !bypass[k]) din[k] = {hdr, tx_scramble(k, p)};
                else                              din[k] = LCB'({$urandom(), $urandom(), $urandom()});
            end
            tick();
        end

        // Error counter saturation and clear-with-bad
        en = 1'b1; valid = '1; bypass = '0; clr = 1'b0;
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < NL; k++) din[k] = {(k == 0) ? 2'b00 : 2'b10, tx_scramble(k, IDLE)};
            tick();
        end
        check("sat_err0", LCB'(o_err[0 +: EW]), LCB'(15));
        clr = 1'b1;
        for (int k = 0; k < NL; k++) din[k] = {(k == 0) ? 2'b11 : 2'b10, tx_scramble(k, IDLE)};
        tick();
        clr = 1'b0;
        check("clr_bad_err0", LCB'(o_err[0 +: EW]), LCB'(1));
        check("clr_good_err3", LCB'(o_err[3*EW +: EW]), '0);

        // Reset in the middle of a valid stream, then relock
        for (int j = 0; j < 5; j++) begin
            send_good(IDLE);
            tick();
        end
        rst = 1'b1;
        send_good(IDLE);
        tick();
        check("midrst_data", o_data[NL*LCB-1 -: LCB], '0);
        check("midrst_valid", LCB'(o_valid), '0);
        check("midrst_lock", LCB'(o_lock), '0);
        check("midrst_err", LCB'(o_err), '0);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            send_good(IDLE);
            tick();
            check($sformatf("relock_blk%0d", j), LCB'(o_lock), (j >= 3) ? LCB'(4'hF) : '0);
        end

        valid = '0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
